// File: rtl/counter_host_pkg.sv
// counter_host_pkg: shared types and fixed phase lengths for counter_host.
//   state_e  - host sequencer states
//   LoadLen  - cycles the host drives the load value onto the bus
//   ArmLen   - bus turnaround cycles between LOAD and TRIG
package counter_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StTrig,
    StRun,
    StDone
  } state_e;

  localparam int unsigned LoadLen = 2;
  localparam int unsigned ArmLen  = 1;

endpackage

// File: rtl/bus_iobuf.sv
// bus_iobuf: tri-state driver for the shared counter bus.
//   oe  - output enable; 1 drives d onto pad, 0 releases pad (high-Z)
//   d   - value to drive
//   pad - shared bidirectional bus
module bus_iobuf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] d,
  inout  wire  [WIDTH-1:0] pad
);

  assign pad = oe ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/counter_host.sv
// counter_host: sequences one counter transaction over a shared tri-state bus.
// Loads a value into the counter, pulses trig, then watches out_pulse until the
// requested number of pulses has been seen.
//
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   start         - transaction request, honoured only in IDLE
//   load_val      - value loaded into the counter
//   pulse_target  - out_pulse events to wait for (0 skips RUN)
//   bus           - shared bus; host drives it only while we=0
//   we            - bus direction, 0 = host drives, 1 = counter drives
//   trig          - counter trigger, high TRIG_LEN cycles
//   out_pulse     - counter terminal pulse, counted only in RUN
//   busy, done    - status; done is a one-cycle completion strobe
//   rd_data       - last bus value sampled in RUN
//   pulse_cnt     - out_pulse events seen this transaction (saturating)
//   timeout       - sticky RUN-abort flag
//
// Build option: define COUNTER_HOST_TIMEOUT_EN to abort RUN after TIMEOUT
// cycles. Without it RUN waits indefinitely and timeout stays 0.
module counter_host
  import counter_host_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TRIG_LEN = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [7:0]       pulse_target,
  inout  wire  [WIDTH-1:0] bus,
  output logic             we,
  output logic             trig,
  input  logic             out_pulse,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       pulse_cnt,
  output logic             timeout
);

  localparam logic [3:0] LoadLast = 4'(LoadLen - 1);
  localparam logic [3:0] ArmLast  = 4'(ArmLen - 1);
  localparam logic [3:0] TrigLast = 4'(TRIG_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             we_q, we_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

`ifdef COUNTER_HOST_TIMEOUT_EN
  localparam int unsigned RunW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RunW-1:0] RunLast = RunW'(TIMEOUT - 1);
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    target_d    = target_q;
    pulse_cnt_d = pulse_cnt_q;
    rd_data_d   = rd_data_q;
    timeout_d   = timeout_q;
`ifdef COUNTER_HOST_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_d      = load_val;
          target_d    = pulse_target;
          pulse_cnt_d = '0;
          timeout_d   = 1'b0;
          cnt_d       = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (cnt_q == LoadLast) begin
          cnt_d   = '0;
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StArm: begin
        if (cnt_q == ArmLast) begin
          cnt_d   = '0;
          state_d = StTrig;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StTrig: begin
        if (cnt_q == TrigLast) begin
          cnt_d   = '0;
          state_d = (target_q == 8'd0) ? StDone : StRun;
`ifdef COUNTER_HOST_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRun: begin
        rd_data_d = bus;
        // Exit is decided on the registered count, so DONE follows the
        // cycle in which the target was reached; the exit cycle counts nothing.
        if (pulse_cnt_q == target_q) begin
          state_d = StDone;
        end
`ifdef COUNTER_HOST_TIMEOUT_EN
        else if (run_cnt_q == RunLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
`endif
        else begin
          if (out_pulse && (pulse_cnt_q != 8'hff)) begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
          end
`ifdef COUNTER_HOST_TIMEOUT_EN
          run_cnt_d = run_cnt_q + RunW'(1);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies decoded from the next state.
    we_d   = (state_d != StLoad);
    trig_d = (state_d == StTrig);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_q      <= '0;
      target_q    <= '0;
      pulse_cnt_q <= '0;
      rd_data_q   <= '0;
      we_q        <= 1'b1;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef COUNTER_HOST_TIMEOUT_EN
      run_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      target_q    <= target_d;
      pulse_cnt_q <= pulse_cnt_d;
      rd_data_q   <= rd_data_d;
      we_q        <= we_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
`ifdef COUNTER_HOST_TIMEOUT_EN
      run_cnt_q   <= run_cnt_d;
`endif
    end
  end

  // Host drives only while we=0, so it never overlaps the counter.
  bus_iobuf #(
    .WIDTH (WIDTH)
  ) u_bus_iobuf (
    .oe  (~we_q),
    .d   (load_q),
    .pad (bus)
  );

  assign we        = we_q;
  assign trig      = trig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign pulse_cnt = pulse_cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/counter_host.md
COUNTER_HOST -- requirements
Module: counter_host

Interface
REQ-001 Parameter WIDTH, default 4: width of the shared counter bus and of load_val/rd_data.
REQ-002 Parameter TRIG_LEN, default 2: number of cycles trig is held high per transaction (legal range 1..15).
REQ-003 Parameter TIMEOUT, default 255: maximum RUN-state cycles when the timeout feature is compiled in.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle transaction request; sampled only in IDLE.
REQ-007 load_val  input  WIDTH  value written to the counter.
REQ-008 pulse_target  input  8  number of out_pulse events to wait for; captured with start.
REQ-009 bus  inout  WIDTH  shared tri-state counter bus; driven with the captured load value when we=0, otherwise high-Z.
REQ-010 we  output  1  bus direction; 0 = host drives/counter loads, 1 = counter drives.
REQ-011 trig  output  1  counter trigger.
REQ-012 out_pulse  input  1  counter terminal pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion strobe.
REQ-015 rd_data  output  WIDTH  last bus value sampled in RUN.
REQ-016 pulse_cnt  output  8  out_pulse events counted in the current transaction.
REQ-017 timeout  output  1  sticky flag; set when RUN is aborted by the timeout.

Function
REQ-018 FSM states: IDLE, LOAD, ARM, TRIG, RUN, DONE; all outputs are registered.
REQ-019 IDLE: we=1, trig=0, bus high-Z; start=1 captures load_val and pulse_target, clears pulse_cnt and timeout, and moves to LOAD.
REQ-020 LOAD lasts exactly 2 cycles with we=0 and bus=captured load value; then ARM.
REQ-021 ARM lasts 1 cycle with we=1, bus high-Z and trig=0 (bus turnaround); then TRIG.
REQ-022 TRIG holds trig=1 for exactly TRIG_LEN cycles; then RUN, or DONE directly if the captured pulse_target is 0.
REQ-023 RUN: rd_data is loaded from bus every cycle; each cycle with out_pulse=1 increments pulse_cnt.
REQ-024 RUN exits to DONE in the cycle after pulse_cnt reaches pulse_target; pulse_cnt saturates at 255.
REQ-025 DONE: done=1 for one cycle; rd_data and pulse_cnt hold; next state IDLE.
REQ-026 start asserted outside IDLE is ignored, and is not queued.
REQ-027 Host drives bus only while we=0, so there is never a cycle where host and counter both drive the bus.
REQ-028 out_pulse outside RUN is ignored.

Reset
REQ-029 rst=0 at a clock edge forces IDLE from any state, including mid-LOAD and mid-RUN.
REQ-030 Reset values: we=1, trig=0, bus high-Z, busy=0, done=0, rd_data=0, pulse_cnt=0, timeout=0, internal counters 0.

Configuration
REQ-031 With COUNTER_HOST_TIMEOUT_EN defined, a RUN cycle counter aborts RUN after TIMEOUT cycles, sets timeout=1 and moves to DONE.
REQ-032 Without COUNTER_HOST_TIMEOUT_EN, RUN waits indefinitely, timeout is tied to 0 and TIMEOUT is unused.

Structure
REQ-033 Package counter_host_pkg holds the state enum typedef, the LOAD length constant (2) and the ARM length constant (1).
REQ-034 The tri-state driver is a sub-module bus_iobuf (ports: oe, d, pad), instantiated once.

Verification
REQ-035 Bench pairs counter_host with the counter (WIDTH=4); start with load_val=5, pulse_target=1 -> we=0 for 2 cycles with bus=5, trig high 2 cycles, done after the first out_pulse, pulse_cnt=1.
REQ-036 pulse_target=0, load_val=11 -> IDLE to DONE in 2+1+2+1 = 6 cycles with no RUN cycles, and done pulses once.
REQ-037 start asserted again during RUN -> ignored; exactly one done per accepted start.
REQ-038 rst=0 during LOAD -> next cycle: we=1, bus high-Z, busy=0, and no X on bus at any time.
REQ-039 With COUNTER_HOST_TIMEOUT_EN and TIMEOUT=20, out_pulse held 0 -> timeout=1 and done 20 cycles after RUN entry; without the macro, busy stays 1.
REQ-040 Checker in every scenario: bus is never driven by both sides (no X on bus while we=1), and rd_data matches the counter output each RUN cycle.
